// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score counter
// Purpose : state encoding, digit count and BCD limits used by score_counter
//           and bcd_digit, plus an MSD-first BCD magnitude compare.
// Ports   : none (package).
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int         NUM_DIGITS = 6;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    // True when BCD value a is strictly greater than b; the first differing
    // digit from the most-significant end decides.
    function automatic logic bcd_greater(input logic [4*NUM_DIGITS-1:0] a,
                                         input logic [4*NUM_DIGITS-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/score_counter_bcd_digit.sv
// rtl/score_counter_bcd_digit.sv - one BCD digit of the score carry chain
// Purpose : single decimal digit register with clear, increment and hold.
// Ports   : clk    - system clock
//           resetn - asynchronous active-low reset
//           clr    - synchronous clear to 0 (highest priority)
//           inc    - increment request (carry-in from the lower digit)
//           hold   - freeze the digit even when inc is set
//           q      - registered BCD value 0..9
//           carry  - carry-out, inc while q is 9
module bcd_digit
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       inc,
    input  logic       hold,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = inc & (q == BCD_MAX);

    // q is written only on clear or an effective increment, so it keeps its
    // value in every other cycle without a self-assignment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc && !hold) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/score_counter.sv
// rtl/score_counter.sv - six-digit BCD game score counter
// Purpose : counts score points at a fixed tick rate while a round runs,
//           freezes on game over, saturates at 999999. Optional session
//           high score is built when SCORE_HISCORE_EN is defined.
// Ports   : clk, resetn (async active-low)
//           start, game_over          - round control pulses
//           digit0..digit5            - BCD score, digit0 least significant
//           running                   - high in RUN
//           milestone                 - one-cycle pulse at nonzero multiples of 100
//           saturated                 - high while score is 999999
//           hi_digit0..hi_digit5      - BCD high score (0 without SCORE_HISCORE_EN)
//           new_high                  - last round beat the high score
module score_counter #(
    parameter int TICK_DIV = 5000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       game_over,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit5,
    output logic       running,
    output logic       milestone,
    output logic       saturated,
    output logic [3:0] hi_digit0,
    output logic [3:0] hi_digit1,
    output logic [3:0] hi_digit2,
    output logic [3:0] hi_digit3,
    output logic [3:0] hi_digit4,
    output logic [3:0] hi_digit5,
    output logic       new_high
);
    import score_pkg::*;

    localparam int PW = $clog2(TICK_DIV);

    state_t              state;
    logic [PW-1:0]       presc;
    logic [3:0]          d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] c;
    logic                unused_carry;
    logic [4*NUM_DIGITS-1:0] score;
    logic                wrap;
    logic                inc0;
    logic                hold;
    logic                clr;

    assign score = {d[5], d[4], d[3], d[2], d[1], d[0]};
    assign saturated = (score == 24'h999999);

    assign wrap = (state == ST_RUN) && (presc == PW'(TICK_DIV - 1));
    // Saturation gates the chain at its root, so the score can never roll over.
    assign inc0 = wrap & ~saturated;
    // game_over beats a coincident wrap by freezing every digit.
    assign hold = (state != ST_RUN) | game_over;
    // From IDLE the score is already 0; only a restart from OVER clears it.
    assign clr  = (state == ST_OVER) & start;
    assign c[0] = inc0;

    bcd_digit u_d0 (.clk(clk), .resetn(resetn), .clr(clr), .inc(c[0]), .hold(hold), .q(d[0]), .carry(c[1]));
    bcd_digit u_d1 (.clk(clk), .resetn(resetn), .clr(clr), .inc(c[1]), .hold(hold), .q(d[1]), .carry(c[2]));
    bcd_digit u_d2 (.clk(clk), .resetn(resetn), .clr(clr), .inc(c[2]), .hold(hold), .q(d[2]), .carry(c[3]));
    bcd_digit u_d3 (.clk(clk), .resetn(resetn), .clr(clr), .inc(c[3]), .hold(hold), .q(d[3]), .carry(c[4]));
    bcd_digit u_d4 (.clk(clk), .resetn(resetn), .clr(clr), .inc(c[4]), .hold(hold), .q(d[4]), .carry(c[5]));
    bcd_digit u_d5 (.clk(clk), .resetn(resetn), .clr(clr), .inc(c[5]), .hold(hold), .q(d[5]), .carry(unused_carry));

    assign digit0 = d[0];
    assign digit1 = d[1];
    assign digit2 = d[2];
    assign digit3 = d[3];
    assign digit4 = d[4];
    assign digit5 = d[5];

`ifdef SCORE_HISCORE_EN
    logic [4*NUM_DIGITS-1:0] hi_score;

    assign hi_digit0 = hi_score[3:0];
    assign hi_digit1 = hi_score[7:4];
    assign hi_digit2 = hi_score[11:8];
    assign hi_digit3 = hi_score[15:12];
    assign hi_digit4 = hi_score[19:16];
    assign hi_digit5 = hi_score[23:20];
`else
    assign hi_digit0 = 4'd0;
    assign hi_digit1 = 4'd0;
    assign hi_digit2 = 4'd0;
    assign hi_digit3 = 4'd0;
    assign hi_digit4 = 4'd0;
    assign hi_digit5 = 4'd0;
    assign new_high  = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            presc     <= '0;
            milestone <= 1'b0;
`ifdef SCORE_HISCORE_EN
            hi_score  <= '0;
            new_high  <= 1'b0;
`endif
        end else begin
            milestone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        presc   <= '0;
                    end
                end
                ST_RUN: begin
                    if (game_over) begin
                        state   <= ST_OVER;
                        running <= 1'b0;
                        presc   <= '0;
`ifdef SCORE_HISCORE_EN
                        if (bcd_greater(score, hi_score)) begin
                            hi_score <= score;
                            new_high <= 1'b1;
                        end
`endif
                    end else begin
                        presc <= wrap ? '0 : presc + PW'(1);
                        // An increment from x99 lands on a multiple of 100.
                        milestone <= inc0 && (d[0] == BCD_MAX) && (d[1] == BCD_MAX);
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        presc   <= '0;
`ifdef SCORE_HISCORE_EN
                        new_high <= 1'b0;
`endif
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    presc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - directed self-checking bench for score_counter
module tb_score_counter;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       game_over;
    logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5;
    logic       running;
    logic       milestone;
    logic       saturated;
    logic [3:0] hi_digit0, hi_digit1, hi_digit2, hi_digit3, hi_digit4, hi_digit5;
    logic       new_high;

    int passed;
    int total;

    score_counter #(.TICK_DIV(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .game_over(game_over),
        .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .digit3(digit3), .digit4(digit4), .digit5(digit5),
        .running(running), .milestone(milestone), .saturated(saturated),
        .hi_digit0(hi_digit0), .hi_digit1(hi_digit1), .hi_digit2(hi_digit2),
        .hi_digit3(hi_digit3), .hi_digit4(hi_digit4), .hi_digit5(hi_digit5),
        .new_high(new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] score_now();
        return {digit5, digit4, digit3, digit2, digit1, digit0};
    endfunction

    function automatic logic [23:0] hi_now();
        return {hi_digit5, hi_digit4, hi_digit3, hi_digit2, hi_digit1, hi_digit0};
    endfunction

    // Pulses leave the bench at the negedge right after the sampling edge N.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_game_over();
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; game_over = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (score_now() !== 24'h000000) $display("FAIL reset_score got %h want 000000", score_now()); else passed++;
        total++; if ({running, milestone, saturated, new_high} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {running, milestone, saturated, new_high}); else passed++;
        total++; if (hi_now() !== 24'h000000) $display("FAIL reset_hi got %h want 000000", hi_now()); else passed++;
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        total++; if ({running, score_now()} !== 25'h0) $display("FAIL idle_hold got %h want 0", {running, score_now()}); else passed++;
    endtask

    task automatic test_start();
        pulse_start();
        total++; if (running !== 1'b1) $display("FAIL start_running got %b want 1", running); else passed++;
        repeat (3) @(negedge clk);
        total++; if (score_now() !== 24'h000000) $display("FAIL start_before_first got %h want 000000", score_now()); else passed++;
        @(negedge clk);
        total++; if (score_now() !== 24'h000001) $display("FAIL start_first_inc got %h want 000001", score_now()); else passed++;
        repeat (8) @(negedge clk);
        total++; if (score_now() !== 24'h000003) $display("FAIL start_third_inc got %h want 000003", score_now()); else passed++;
        pulse_game_over();
    endtask

    task automatic test_milestone();
        int ms_count;
        ms_count = 0;
        pulse_start();
        total++; if (score_now() !== 24'h000000) $display("FAIL restart_clear got %h want 000000", score_now()); else passed++;
        repeat (4 * 99) begin
            @(negedge clk);
            if (milestone) ms_count++;
        end
        total++; if (score_now() !== 24'h000099) $display("FAIL ms_at_99 got %h want 000099", score_now()); else passed++;
        repeat (4) begin
            @(negedge clk);
            if (milestone) ms_count++;
        end
        total++; if (score_now() !== 24'h000100) $display("FAIL ms_carry got %h want 000100", score_now()); else passed++;
        total++; if (milestone !== 1'b1) $display("FAIL ms_pulse got %b want 1", milestone); else passed++;
        @(negedge clk);
        if (milestone) ms_count++;
        total++; if (milestone !== 1'b0) $display("FAIL ms_one_cycle got %b want 0", milestone); else passed++;
        total++; if (ms_count !== 1) $display("FAIL ms_count got %0d want 1", ms_count); else passed++;
        pulse_game_over();
        total++; if (running !== 1'b0) $display("FAIL over_running got %b want 0", running); else passed++;
        pulse_game_over();
        repeat (8) @(negedge clk);
        total++; if (score_now() !== 24'h000100) $display("FAIL over_frozen got %h want 000100", score_now()); else passed++;
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        pulse_start();
        dut.u_d0.q = 4'd8;
        dut.u_d1.q = 4'd9;
        dut.u_d2.q = 4'd9;
        dut.u_d3.q = 4'd9;
        dut.u_d4.q = 4'd9;
        dut.u_d5.q = 4'd9;
        @(negedge clk);
        total++; if (saturated !== 1'b0) $display("FAIL sat_early got %b want 0", saturated); else passed++;
        repeat (3) @(negedge clk);
        total++; if ({saturated, score_now()} !== {1'b1, 24'h999999}) $display("FAIL sat_reach got %h want 1999999", {saturated, score_now()}); else passed++;
        repeat (4) @(negedge clk);
        total++; if (score_now() !== 24'h999999) $display("FAIL sat_second_wrap got %h want 999999", score_now()); else passed++;
        repeat (40) begin
            @(negedge clk);
            if (score_now() !== 24'h999999 || saturated !== 1'b1 || milestone !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL sat_hold got %0d bad cycles want 0", bad); else passed++;
        pulse_game_over();
    endtask

    task automatic test_go_wrap();
        pulse_start();
        repeat (4 * 42) @(negedge clk);
        total++; if (score_now() !== 24'h000042) $display("FAIL gw_at_42 got %h want 000042", score_now()); else passed++;
        repeat (3) @(negedge clk);
        pulse_game_over();
        total++; if ({running, score_now()} !== {1'b0, 24'h000042}) $display("FAIL gw_frozen got %h want 0000042", {running, score_now()}); else passed++;
        repeat (8) @(negedge clk);
        total++; if (score_now() !== 24'h000042) $display("FAIL gw_stable got %h want 000042", score_now()); else passed++;
        // Held start: the second sampled cycle is in RUN and must not restart the prescaler.
        start = 1'b1;
        @(negedge clk);
        total++; if ({running, score_now()} !== {1'b1, 24'h000000}) $display("FAIL gw_restart got %h want 1000000", {running, score_now()}); else passed++;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (score_now() !== 24'h000001) $display("FAIL gw_held_start got %h want 000001", score_now()); else passed++;
        pulse_game_over();
    endtask

    task automatic test_hiscore();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        pulse_start();
        repeat (4 * 57) @(negedge clk);
        pulse_game_over();
        total++; if (score_now() !== 24'h000057) $display("FAIL hs_r1_score got %h want 000057", score_now()); else passed++;
`ifdef SCORE_HISCORE_EN
        total++; if ({new_high, hi_now()} !== {1'b1, 24'h000057}) $display("FAIL hs_r1 got %h want 1000057", {new_high, hi_now()}); else passed++;
        pulse_start();
        total++; if (new_high !== 1'b0) $display("FAIL hs_clear_on_start got %b want 0", new_high); else passed++;
        repeat (4 * 30 - 1) @(negedge clk);
        pulse_game_over();
        total++; if ({new_high, hi_now()} !== {1'b0, 24'h000057}) $display("FAIL hs_r2 got %h want 0000057", {new_high, hi_now()}); else passed++;
        pulse_start();
        repeat (4 * 57) @(negedge clk);
        pulse_game_over();
        total++; if ({new_high, hi_now(), score_now()} !== {1'b0, 24'h000057, 24'h000057}) $display("FAIL hs_r3_equal got %h want 0000057000057", {new_high, hi_now(), score_now()}); else passed++;
`else
        total++; if ({new_high, hi_now()} !== 25'h0) $display("FAIL hs_disabled got %h want 0", {new_high, hi_now()}); else passed++;
`endif
    endtask

    task automatic test_reset_midround();
        pulse_start();
        repeat (4 * 15) @(negedge clk);
        total++; if (score_now() !== 24'h000015) $display("FAIL mr_at_15 got %h want 000015", score_now()); else passed++;
        resetn = 1'b0;
        #2;
        total++; if ({running, new_high, score_now(), hi_now()} !== 50'h0) $display("FAIL mr_async got %h want 0", {running, new_high, score_now(), hi_now()}); else passed++;
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        total++; if ({running, score_now()} !== 25'h0) $display("FAIL mr_needs_start got %h want 0", {running, score_now()}); else passed++;
        pulse_start();
        repeat (4) @(negedge clk);
        total++; if ({running, score_now()} !== {1'b1, 24'h000001}) $display("FAIL mr_resume got %h want 1000001", {running, score_now()}); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_start();
        test_milestone();
        test_saturation();
        test_go_wrap();
        test_hiscore();
        test_reset_midround();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
